// File: rtl/morse_encoder.sv
// Morse encoder: ASCII characters in over valid/ready, on/off keyed stream out.
// One symbol per Morse unit: dot=1, dash=111, element gap=0, letter gap=000,
// space adds 0000 after the letter gap, giving the 7-unit word gap.
//
// state  | meaning
// IDLE   | waiting for a character, output low, ready high
// MARK   | keying one element (1 unit dot, 3 units dash)
// EGAP   | 1-unit gap between elements of one character
// LGAP   | 3-unit gap after the last element of a character
// WGAP   | 4-unit gap emitted for a space character
module morse_encoder #(
    parameter int UNIT_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       signal_out,
    output logic       busy,
    output logic       char_err
);

    localparam int UW = $clog2(UNIT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_MARK, S_EGAP, S_LGAP, S_WGAP} state_e;

    typedef struct packed {
        logic       ok;
        logic       space;
        logic [2:0] len;
        logic [4:0] pat;
    } rom_t;

    // Pattern is right-aligned in pat[len-1:0], first element in the MSB, 1 = dash.
    function automatic rom_t rom_lookup(input logic [7:0] c);
        logic [7:0] u;
        rom_t       r;
        u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
        r = '{ok: 1'b1, space: 1'b0, len: 3'd0, pat: 5'd0};
        case (u)
            8'h20: r.space = 1'b1;
            "A": {r.len, r.pat} = {3'd2, 5'b00001};
            "B": {r.len, r.pat} = {3'd4, 5'b01000};
            "C": {r.len, r.pat} = {3'd4, 5'b01010};
            "D": {r.len, r.pat} = {3'd3, 5'b00100};
            "E": {r.len, r.pat} = {3'd1, 5'b00000};
            "F": {r.len, r.pat} = {3'd4, 5'b00010};
            "G": {r.len, r.pat} = {3'd3, 5'b00110};
            "H": {r.len, r.pat} = {3'd4, 5'b00000};
            "I": {r.len, r.pat} = {3'd2, 5'b00000};
            "J": {r.len, r.pat} = {3'd4, 5'b00111};
            "K": {r.len, r.pat} = {3'd3, 5'b00101};
            "L": {r.len, r.pat} = {3'd4, 5'b00100};
            "M": {r.len, r.pat} = {3'd2, 5'b00011};
            "N": {r.len, r.pat} = {3'd2, 5'b00010};
            "O": {r.len, r.pat} = {3'd3, 5'b00111};
            "P": {r.len, r.pat} = {3'd4, 5'b00110};
            "Q": {r.len, r.pat} = {3'd4, 5'b01101};
            "R": {r.len, r.pat} = {3'd3, 5'b00010};
            "S": {r.len, r.pat} = {3'd3, 5'b00000};
            "T": {r.len, r.pat} = {3'd1, 5'b00001};
            "U": {r.len, r.pat} = {3'd3, 5'b00001};
            "V": {r.len, r.pat} = {3'd4, 5'b00001};
            "W": {r.len, r.pat} = {3'd3, 5'b00011};
            "X": {r.len, r.pat} = {3'd4, 5'b01001};
            "Y": {r.len, r.pat} = {3'd4, 5'b01011};
            "Z": {r.len, r.pat} = {3'd4, 5'b01100};
            "0": {r.len, r.pat} = {3'd5, 5'b11111};
            "1": {r.len, r.pat} = {3'd5, 5'b01111};
            "2": {r.len, r.pat} = {3'd5, 5'b00111};
            "3": {r.len, r.pat} = {3'd5, 5'b00011};
            "4": {r.len, r.pat} = {3'd5, 5'b00001};
            "5": {r.len, r.pat} = {3'd5, 5'b00000};
            "6": {r.len, r.pat} = {3'd5, 5'b10000};
            "7": {r.len, r.pat} = {3'd5, 5'b11000};
            "8": {r.len, r.pat} = {3'd5, 5'b11100};
            "9": {r.len, r.pat} = {3'd5, 5'b11110};
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [UW-1:0] unit_cnt_q, unit_cnt_d;
    logic [1:0]  sym_cnt_q, sym_cnt_d;
    logic [2:0]  elem_left_q, elem_left_d;
    logic [4:0]  shift_q, shift_d;
    logic        signal_out_q, signal_out_d;
    logic        char_err_q, char_err_d;

    logic        unit_last;
    logic        state_last;
    logic [1:0]  dur_last;
    logic        accept;
    rom_t        rom;

    // Unit timebase, per-state duration, handshake and next-state decode.
    always_comb begin
        unit_cnt_d   = unit_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        elem_left_d  = elem_left_q;
        shift_d      = shift_q;
        state_d      = state_q;
        char_err_d   = 1'b0;
        dur_last     = 2'd0;
        rom          = rom_lookup(char_in);

        unit_last = (unit_cnt_q == UW'(UNIT_CYCLES - 1));
        case (state_q)
            S_MARK:  dur_last = shift_q[4] ? 2'd2 : 2'd0;
            S_LGAP:  dur_last = 2'd2;
            S_WGAP:  dur_last = 2'd3;
            default: dur_last = 2'd0;
        endcase
        state_last = (state_q != S_IDLE) && unit_last && (sym_cnt_q == dur_last);
        char_ready = (state_q == S_IDLE) ||
                     (((state_q == S_LGAP) || (state_q == S_WGAP)) && state_last);
        accept     = char_valid && char_ready;

        if (state_q != S_IDLE) begin
            unit_cnt_d = unit_last ? '0 : (unit_cnt_q + UW'(1));
            if (unit_last) sym_cnt_d = sym_cnt_q + 2'd1;
        end

        if (state_last) begin
            sym_cnt_d = 2'd0;
            case (state_q)
                S_MARK: begin
                    elem_left_d = elem_left_q - 3'd1;
                    state_d     = (elem_left_q == 3'd1) ? S_LGAP : S_EGAP;
                end
                S_EGAP: begin
                    shift_d = {shift_q[3:0], 1'b0};
                    state_d = S_MARK;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A new character overrides the gap exit; the accepting edge starts its first unit.
        if (accept) begin
            unit_cnt_d = '0;
            sym_cnt_d  = 2'd0;
            if (!rom.ok) begin
                char_err_d = 1'b1;
                state_d    = S_IDLE;
            end else if (rom.space) begin
                state_d = S_WGAP;
            end else begin
                shift_d     = rom.pat << (3'd5 - rom.len);
                elem_left_d = rom.len;
                state_d     = S_MARK;
            end
        end

        signal_out_d = (state_d == S_MARK);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            unit_cnt_q   <= '0;
            sym_cnt_q    <= 2'd0;
            elem_left_q  <= 3'd0;
            shift_q      <= 5'd0;
            signal_out_q <= 1'b0;
            char_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_cnt_q   <= unit_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            elem_left_q  <= elem_left_d;
            shift_q      <= shift_d;
            signal_out_q <= signal_out_d;
            char_err_q   <= char_err_d;
        end
    end

    assign signal_out = signal_out_q;
    assign char_err   = char_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: reference model expands each accepted character into
// its dot/dash text, then into a queue of expected output units.
module tb_morse_encoder;

    logic       clock;
    logic       reset_n;
    logic [7:0] char_in, char_in3;
    logic       char_valid, char_valid3;
    logic       char_ready, char_ready3;
    logic       signal_out, signal_out3;
    logic       busy, busy3;
    logic       char_err, char_err3;

    int checks = 0;
    int errors = 0;

    bit q[$];
    bit exp_err;

    morse_encoder #(.UNIT_CYCLES(1)) dut (
        .clock(clock), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .signal_out(signal_out), .busy(busy), .char_err(char_err)
    );

    morse_encoder #(.UNIT_CYCLES(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .char_in(char_in3), .char_valid(char_valid3),
        .char_ready(char_ready3), .signal_out(signal_out3), .busy(busy3), .char_err(char_err3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // International Morse text; "_" marks space, "" marks unsupported.
    function automatic string code_of(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
        case (u)
            8'h20: return "_";
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
            "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
            "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
            "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
            "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
            "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
            "8": return "---.."; "9": return "----.";
            default: return "";
        endcase
    endfunction

    task automatic model_accept(input logic [7:0] c);
        string s;
        s = code_of(c);
        if (s.len() == 0) begin
            exp_err = 1'b1;
        end else if (s == "_") begin
            repeat (4) q.push_back(1'b0);
        end else begin
            for (int i = 0; i < s.len(); i++) begin
                if (i > 0) q.push_back(1'b0);
                if (s[i] == "-") repeat (3) q.push_back(1'b1);
                else q.push_back(1'b1);
            end
            repeat (3) q.push_back(1'b0);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_sig"},  {31'd0, signal_out}, {31'd0, (q.size() != 0) ? q[0] : 1'b0});
        check({tag, "_busy"}, {31'd0, busy},       {31'd0, q.size() != 0});
        check({tag, "_rdy"},  {31'd0, char_ready}, {31'd0, q.size() <= 1});
        check({tag, "_err"},  {31'd0, char_err},   {31'd0, exp_err});
    endtask

    // Called at a negedge: drive, cross one posedge, update model, check at next negedge.
    task automatic step(input bit v, input logic [7:0] c, input string tag, output bit acc);
        char_valid = v;
        char_in    = c;
        acc        = v && (q.size() <= 1);
        @(posedge clock);
        if (q.size() != 0) void'(q.pop_front());
        exp_err = 1'b0;
        if (acc) model_accept(c);
        @(negedge clock);
        check_outputs(tag);
    endtask

    task automatic send_held(input logic [7:0] c, input string tag);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 64) begin
            step(1'b1, c, tag, acc);
            n++;
        end
        if (!acc) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), tag, acc);
    endtask

    function automatic logic [7:0] rand_char();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3: return 8'(8'h41 + $urandom_range(0, 25));
            4, 5:       return 8'(8'h61 + $urandom_range(0, 25));
            6, 7:       return 8'(8'h30 + $urandom_range(0, 9));
            8:          return 8'h20;
            default:    return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        string phrase;
        bit acc;
        reset_n     = 1'b0;
        char_valid  = 1'b0;
        char_in     = 8'h00;
        char_valid3 = 1'b0;
        char_in3    = 8'h00;
        exp_err     = 1'b0;
        repeat (3) @(negedge clock);
        check_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);
        check_outputs("post_reset");

        // Single N, then a/A, then held-valid phrase.
        send_held("N", "n_once");
        idle_cycles(10, "n_tail");
        send_held("a", "lower_a");
        idle_cycles(9, "a_tail");
        send_held("A", "upper_a");
        idle_cycles(9, "A_tail");

        phrase = "NO PAIN NO GAIN";
        for (int i = 0; i < phrase.len(); i++) send_held(phrase[i], "phrase");
        idle_cycles(12, "phrase_tail");

        // Unsupported character, then E; also a leading space.
        send_held(8'h23, "hash");
        idle_cycles(2, "hash_tail");
        send_held("E", "e_after_hash");
        idle_cycles(5, "e_tail");
        send_held(8'h20, "lead_space");
        send_held("T", "t_after_space");
        send_held(8'h7E, "bad_in_gap");
        idle_cycles(8, "bad_tail");

        // Async reset during the third dash of O.
        send_held("O", "o_start");
        idle_cycles(8, "o_run");
        check("o_third_dash_pre", {31'd0, signal_out}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_sig",  {31'd0, signal_out}, 32'd0);
        check("async_rst_busy", {31'd0, busy},       32'd0);
        check("async_rst_rdy",  {31'd0, char_ready}, 32'd1);
        q.delete();
        exp_err = 1'b0;
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_outputs("after_rst");
        send_held("E", "e_after_rst");
        idle_cycles(5, "e2_tail");

        // Randomized traffic with random valid and a changing char_in.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 7, rand_char(), "rand", acc);
        idle_cycles(25, "rand_tail");

        // UNIT_CYCLES=3 instance: T is 9 ones then 9 zeros, busy for 18 cycles.
        char_valid3 = 1'b1;
        char_in3    = "T";
        check("u3_ready_idle", {31'd0, char_ready3}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        char_valid3 = 1'b0;
        char_in3    = "E";
        for (int i = 0; i < 22; i++) begin
            check("u3_sig",  {31'd0, signal_out3}, {31'd0, i < 9});
            check("u3_busy", {31'd0, busy3},       {31'd0, i < 18});
            check("u3_rdy",  {31'd0, char_ready3}, {31'd0, i >= 17});
            check("u3_err",  {31'd0, char_err3},   32'd0);
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
